// File: rtl/delay_probe.sv
// delay_probe: launches one stimulus vector into a DUT and times how long the DUT output takes to settle on an expected value.
// Latency: stim_out/busy are valid the cycle after an accepted start; done pulses after edge E0+latency+STABLE-1, or after E0+TIMEOUT.
// Backpressure: none; start is honoured only in IDLE (including the done cycle), and is dropped without queueing while busy.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             measurement request (IDLE only)
//   stim_in/expect_in vector and expected response, captured on an accepted start
//   stim_out          registered stimulus driven to the DUT, held between measurements
//   dut_out           DUT response, same clock domain
//   busy/done         measurement in progress / one-cycle completion pulse
//   timeout           last measurement gave up; cleared by the next accepted start
//   latency           start index of the settling run, or TIMEOUT; held until the next done
//   last_out          most recent dut_out sample taken while waiting
module delay_probe #(
   parameter int IN_W    = 2,
   parameter int OUT_W   = 1,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000,
   parameter int STABLE  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  stim_in,
   input  logic [OUT_W-1:0] expect_in,
   output logic [IN_W-1:0]  stim_out,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] latency,
   output logic [OUT_W-1:0] last_out
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_WAIT = 1'b1;

   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(STABLE);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   logic             r_state;
   logic [IN_W-1:0]  r_stim_out;
   logic [OUT_W-1:0] r_expect;
   logic [CNT_W-1:0] r_idx;        // index of the last sample taken
   logic [CNT_W-1:0] r_run;        // length of the current matching run
   logic [CNT_W-1:0] r_run_start;  // sample index where the current run began
   logic             r_busy;
   logic             r_done;
   logic             r_timeout;
   logic [CNT_W-1:0] r_latency;
   logic [OUT_W-1:0] r_last_out;

   logic             w_match;
   logic [CNT_W-1:0] w_idx_nxt;
   logic [CNT_W-1:0] w_run_nxt;
   logic [CNT_W-1:0] w_run_start_nxt;
   logic             w_settled;
   logic             w_expired;

   // Evaluation of the sample being taken at this edge (index r_idx+1).
   always_comb begin
      w_idx_nxt       = r_idx + C_ONE;
      w_match         = (dut_out == r_expect);
      w_run_nxt       = w_match ? (r_run + C_ONE) : '0;
      // A run starting at this sample takes its index; otherwise keep the old start.
      w_run_start_nxt = (w_match && (r_run == '0)) ? w_idx_nxt : r_run_start;
      w_settled       = (w_run_nxt == C_STABLE);
      // Settling wins over timeout when both land on the same sample.
      w_expired       = (w_idx_nxt == C_TIMEOUT) && !w_settled;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_stim_out  <= '0;
         r_expect    <= '0;
         r_idx       <= '0;
         r_run       <= '0;
         r_run_start <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_latency   <= '0;
         r_last_out  <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_stim_out  <= stim_in;
               r_expect    <= expect_in;
               r_idx       <= '0;
               r_run       <= '0;
               r_run_start <= '0;
               r_timeout   <= 1'b0;
               r_busy      <= 1'b1;
               r_state     <= S_WAIT;
            end
         end else begin
            r_idx       <= w_idx_nxt;
            r_last_out  <= dut_out;
            r_run       <= w_run_nxt;
            r_run_start <= w_run_start_nxt;
            if (w_settled) begin
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_latency <= w_run_start_nxt;
               r_state   <= S_IDLE;
            end else if (w_expired) begin
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_timeout <= 1'b1;
               r_latency <= C_TIMEOUT;
               r_state   <= S_IDLE;
            end
         end
      end
   end

   assign stim_out = r_stim_out;
   assign busy     = r_busy;
   assign done     = r_done;
   assign timeout  = r_timeout;
   assign latency  = r_latency;
   assign last_out = r_last_out;

endmodule
